// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS controller: opcodes, functs,
// ALU control codes, FSM states and the ALU operation selector.
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBne   = 6'b000101;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  localparam logic [3:0] CtlAnd = 4'b0000;
  localparam logic [3:0] CtlOr  = 4'b0001;
  localparam logic [3:0] CtlAdd = 4'b0010;
  localparam logic [3:0] CtlSub = 4'b0110;
  localparam logic [3:0] CtlSlt = 4'b0111;
  localparam logic [3:0] CtlSll = 4'b1000;
  localparam logic [3:0] CtlSrl = 4'b1001;
  localparam logic [3:0] CtlNor = 4'b1100;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  // AluOpNone drives ALUControl to 0 in states that do not use the ALU.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpNone  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: fixed add/sub or funct-field decode, with a
// flag that marks whether the funct is one the datapath supports.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_e    ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] ALUControl,
  output logic       funct_valid
);

  always_comb begin
    ALUControl  = CtlAnd;
    funct_valid = 1'b0;
    unique case (ALUOp)
      AluOpAdd:  ALUControl = CtlAdd;
      AluOpSub:  ALUControl = CtlSub;
      AluOpFunct: begin
        funct_valid = 1'b1;
        case (Funct)
          FnAdd:   ALUControl = CtlAdd;
          FnSub:   ALUControl = CtlSub;
          FnAnd:   ALUControl = CtlAnd;
          FnOr:    ALUControl = CtlOr;
          FnSlt:   ALUControl = CtlSlt;
          FnNor:   ALUControl = CtlNor;
          FnSll:   ALUControl = CtlSll;
          FnSrl:   ALUControl = CtlSrl;
          default: funct_valid = 1'b0;
        endcase
      end
      AluOpNone: ALUControl = CtlAnd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath with a shared, wait-capable memory port.
// Define MULTICYCLE_BNE_EN to decode bne as a branch on ZeroFlag == 0.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       ZeroFlag,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic       MemTimeout
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_MAX - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;
  alu_op_e         alu_op;
  logic            funct_valid;
  logic            mem_state, mem_expire, branch_take;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .funct_valid(funct_valid)
  );

  assign mem_state  = state_q inside {StFetch, StMemRd, StMemWr};
  // The WAIT_MAX-th consecutive not-ready cycle abandons the access.
  assign mem_expire = mem_state && !MemReady && (wait_q == WaitLast);
  assign MemTimeout = timeout_q;

`ifdef MULTICYCLE_BNE_EN
  assign branch_take = (Op == OpBne) ? !ZeroFlag : ZeroFlag;
`else
  assign branch_take = ZeroFlag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    unique case (state_q)
      StFetch:  if (MemReady) state_d = StDecode;
      StDecode: begin
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
`ifdef MULTICYCLE_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (Op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (MemReady) state_d = StMemWb;
      StMemWr:  if (MemReady) state_d = StFetch;
      StExec:   state_d = funct_valid ? StAluWb : StFetch;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
    if (mem_state && !MemReady) begin
      if (mem_expire) begin
        state_d   = StFetch;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    alu_op = AluOpNone;
    if (!reset) begin
      unique case (state_q)
        StFetch, StDecode, StMemAdr, StAddiEx: alu_op = AluOpAdd;
        StExec:                                alu_op = AluOpFunct;
        StBranch:                              alu_op = AluOpSub;
        default:                               alu_op = AluOpNone;
      endcase
    end
  end

  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Illegal  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCEn    = MemReady;
        end
        StDecode: begin
          ALUSrcB = 2'b11;
          Illegal = (state_d == StFetch);
        end
        StMemAdr, StAddiEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExec: begin
          ALUSrcA = 1'b1;
          Illegal = !funct_valid;
        end
        StAluWb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StBranch: begin
          ALUSrcA = 1'b1;
          PCSrc   = 2'b01;
          PCEn    = branch_take;
        end
        StAddiWb: RegWrite = 1'b1;
        StJump: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
